// File: rtl/pid_seq.sv
// Control sequencer for the 14-bit PID datapath: Xset boot load/writes and the Err/P/I/D update sequence.
// Build option PID_DTERM_EN adds the derivative multiply and PreErr update; undefined gives a PI-only sequence.
module pid_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       wrt_xset,
    input  logic [1:0] sel,
    input  logic       finish,
    output logic [2:0] src0_sel,
    output logic [2:0] src1_sel,
    output logic       cmplmnt,
    output logic       init,
    output logic       counter_rst,
    output logic       Duty_en,
    output logic       Err_en,
    output logic       PreErr_en,
    output logic       Xset_en,
    output logic       SumErr_en,
    output logic       mans_en,
    output logic       SumErr_rst,
    output logic       PreErr_rst,
    output logic       XsetEEPrd,
    output logic [1:0] eep_addr,
    output logic       busy,
    output logic       done,
    output logic       ovr
);

    // state    | meaning
    // S_BOOT   | first cycle after reset: load Xset from EEPROM, clear SumErr/PreErr
    // S_IDLE   | wait for go, service Xset writes
    // S_ERR    | Err = Xmeas - Xset
    // S_MUL_P  | init, 14 Booth steps with P, then mans = P*Err/0x800
    // S_INTEG  | SumErr = SumErr + Err
    // S_MUL_I  | Booth with I on SumErr, then accumulate into mans (or Duty)
    // S_MUL_D  | Booth with D on Err-PreErr, then Duty = mans + term
    // S_PREERR | PreErr = Err
    typedef enum logic [2:0] {
        S_BOOT, S_IDLE, S_ERR, S_MUL_P, S_INTEG, S_MUL_I, S_MUL_D, S_PREERR
    } state_t;

    localparam logic [2:0] SRC1_CFG   = 3'b000;
    localparam logic [2:0] SRC1_XMEAS = 3'b001;
    localparam logic [2:0] SRC1_PREG  = 3'b010;
    localparam logic [2:0] SRC1_PROD  = 3'b011;
    localparam logic [2:0] SRC1_ERR   = 3'b101;
    localparam logic [2:0] SRC1_ZERO  = 3'b110;

    localparam logic [2:0] SRC0_PREERR = 3'b000;
    localparam logic [2:0] SRC0_XSET   = 3'b001;
    localparam logic [2:0] SRC0_SUMERR = 3'b010;
    localparam logic [2:0] SRC0_COEFF  = 3'b011;
    localparam logic [2:0] SRC0_ZERO   = 3'b101;
    localparam logic [2:0] SRC0_MANS   = 3'b111;

    state_t state_q, state_d;
    logic   first_q;
    logic   done_q, done_d;
    logic   ovr_q, ovr_d;
    logic   is_mul;
    logic   mul_last;

    assign is_mul   = (state_q == S_MUL_P) || (state_q == S_MUL_I) || (state_q == S_MUL_D);
    assign mul_last = is_mul && !first_q && finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // A go colliding with wrt_xset still moves to ERR; the Xset write lands on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_IDLE;
            S_IDLE:  if (go) state_d = S_ERR;
            S_ERR:   state_d = S_MUL_P;
            S_MUL_P: if (mul_last) state_d = S_INTEG;
            S_INTEG: state_d = S_MUL_I;
`ifdef PID_DTERM_EN
            S_MUL_I:  if (mul_last) state_d = S_MUL_D;
            S_MUL_D:  if (mul_last) state_d = S_PREERR;
            S_PREERR: state_d = S_IDLE;
`else
            S_MUL_I:  if (mul_last) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_BOOT) && (state_q != S_IDLE);
    assign done = done_q;
    assign ovr  = ovr_q;

    always_comb begin
        ovr_d = go && busy;
`ifdef PID_DTERM_EN
        done_d = (state_q == S_PREERR);
`else
        done_d = (state_q == S_MUL_I) && mul_last;
`endif
    end

    // Outputs are forced to idle values while rst_n is held, even though state_q sits at S_BOOT.
    always_comb begin
        src1_sel    = SRC1_ZERO;
        src0_sel    = SRC0_ZERO;
        cmplmnt     = 1'b0;
        init        = 1'b0;
        counter_rst = 1'b1;
        Duty_en     = 1'b0;
        Err_en      = 1'b0;
        PreErr_en   = 1'b0;
        Xset_en     = 1'b0;
        SumErr_en   = 1'b0;
        mans_en     = 1'b0;
        SumErr_rst  = 1'b0;
        PreErr_rst  = 1'b0;
        XsetEEPrd   = 1'b0;
        eep_addr    = 2'd0;
        if (rst_n) begin
            case (state_q)
                S_BOOT: begin
                    XsetEEPrd  = 1'b1;
                    SumErr_rst = 1'b1;
                    PreErr_rst = 1'b1;
                end
                S_IDLE: begin
                    if (wrt_xset) begin
                        src1_sel = SRC1_CFG;
                        Xset_en  = 1'b1;
                    end
                end
                S_ERR: begin
                    src1_sel = SRC1_XMEAS;
                    src0_sel = SRC0_XSET;
                    cmplmnt  = 1'b1;
                    Err_en   = 1'b1;
                end
                S_MUL_P: begin
                    eep_addr = 2'd1;
                    if (first_q) begin
                        src1_sel = SRC1_ERR;
                        init     = 1'b1;
                    end else if (finish) begin
                        src1_sel = SRC1_PROD;
                        mans_en  = 1'b1;
                    end
                end
                S_INTEG: begin
                    src1_sel  = SRC1_ERR;
                    src0_sel  = SRC0_SUMERR;
                    SumErr_en = 1'b1;
                end
                S_MUL_I: begin
                    eep_addr = 2'd2;
                    if (first_q) begin
                        src0_sel = SRC0_SUMERR;
                        init     = 1'b1;
                    end else if (finish) begin
                        src1_sel = SRC1_PROD;
                        src0_sel = SRC0_MANS;
`ifdef PID_DTERM_EN
                        mans_en  = 1'b1;
`else
                        Duty_en  = 1'b1;
`endif
                    end
                end
`ifdef PID_DTERM_EN
                S_MUL_D: begin
                    eep_addr = 2'd3;
                    if (first_q) begin
                        src1_sel = SRC1_ERR;
                        src0_sel = SRC0_PREERR;
                        cmplmnt  = 1'b1;
                        init     = 1'b1;
                    end else if (finish) begin
                        src1_sel = SRC1_PROD;
                        src0_sel = SRC0_MANS;
                        Duty_en  = 1'b1;
                    end
                end
                S_PREERR: begin
                    src1_sel  = SRC1_ERR;
                    PreErr_en = 1'b1;
                end
`endif
                default: ;
            endcase

            // Radix-2 Booth step shared by all three multiplies.
            if (is_mul && !first_q && !finish) begin
                src1_sel    = SRC1_PREG;
                counter_rst = 1'b0;
                case (sel)
                    2'b01:   src0_sel = SRC0_COEFF;
                    2'b10: begin
                        src0_sel = SRC0_COEFF;
                        cmplmnt  = 1'b1;
                    end
                    default: src0_sel = SRC0_ZERO;
                endcase
            end
        end
    end

endmodule
